axi_adc_jesd204_pn_stats: RTL and testbench



---
 rtl/axi_adc_jesd204_pkg.sv | 15 +
 rtl/ad_sat_counter.sv | 35 +++
 rtl/axi_adc_jesd204_pn_stats.sv | 206 ++++++++++++++++++++
 tb/tb_axi_adc_jesd204_pn_stats.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_adc_jesd204_pkg.sv
// Shared state encoding and default widths for the JESD204 ADC PN statistics block.
package axi_adc_jesd204_pkg;

    typedef enum logic [1:0] {
        S_OOS    = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2
    } pn_state_t;

    localparam int DEF_CNT_WIDTH     = 32;
    localparam int DEF_WINDOW_WIDTH  = 24;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int SETTLE_WIDTH      = 8;

endpackage

// File: rtl/ad_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ad_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_q
);

    logic [WIDTH-1:0] cnt_d;

    // next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_adc_jesd204_pn_stats.sv
// Per-channel PN lock qualification, error/loss statistics and windowed error rate.
// Optional longest-error-run tracking is enabled by AXI_ADC_JESD204_PN_STATS_BURST_EN.
module axi_adc_jesd204_pn_stats
    import axi_adc_jesd204_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int WINDOW_WIDTH  = DEF_WINDOW_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                    adc_clk,
    input  logic                    adc_rst,
    input  logic                    adc_pn_oos,
    input  logic                    adc_pn_err,
    input  logic [3:0]              adc_pnseq_sel,
    input  logic                    adc_stats_clr,
    input  logic [WINDOW_WIDTH-1:0] adc_window_len,
    output logic                    adc_locked,
    output logic [CNT_WIDTH-1:0]    adc_err_cnt,
    output logic [CNT_WIDTH-1:0]    adc_loss_cnt,
    output logic                    adc_err_sticky,
    output logic                    adc_loss_sticky,
    output logic [CNT_WIDTH-1:0]    adc_win_err_cnt,
    output logic                    adc_win_done
`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
    ,
    output logic [15:0]             adc_burst_max
`endif
);

    pn_state_t               state_q, state_d;
    logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
    logic [3:0]              pnseq_q;
    logic                    locked_q, locked_d;
    logic                    err_sticky_q, err_sticky_d;
    logic                    loss_sticky_q, loss_sticky_d;
    logic [WINDOW_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_WIDTH-1:0]    win_err_q, win_err_d;
    logic                    win_done_q, win_done_d;
    logic [CNT_WIDTH-1:0]    acc_cnt;
    logic [CNT_WIDTH-1:0]    acc_latch;
    logic                    seq_chg, count_en, loss_ev, win_active, win_end, acc_clr;

    assign seq_chg  = (adc_pnseq_sel != pnseq_q);
    assign count_en = (state_q == S_LOCKED) && !seq_chg && !adc_pn_oos && adc_pn_err;
    assign loss_ev  = (state_q == S_LOCKED) && !seq_chg && adc_pn_oos;

    // lock qualification state machine; a sequence change always forces resync
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (seq_chg) begin
            state_d  = S_OOS;
            settle_d = {SETTLE_WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_OOS: begin
                    settle_d = {SETTLE_WIDTH{1'b0}};
                    if (!adc_pn_oos) begin
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_OOS;
                    end
                end
                S_SETTLE: begin
                    if (adc_pn_oos) begin
                        state_d  = S_OOS;
                        settle_d = {SETTLE_WIDTH{1'b0}};
                    end else if (settle_q == SETTLE_WIDTH'(SETTLE_CYCLES - 1)) begin
                        state_d  = S_LOCKED;
                        settle_d = {SETTLE_WIDTH{1'b0}};
                    end else begin
                        settle_d = settle_q + {{(SETTLE_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                S_LOCKED: begin
                    if (adc_pn_oos) begin
                        state_d = S_OOS;
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
                default: begin
                    state_d  = S_OOS;
                    settle_d = {SETTLE_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // a window only runs while we stay locked; leaving lock aborts it silently
    assign win_active = (state_q == S_LOCKED) && (state_d == S_LOCKED) &&
                        (adc_window_len != {WINDOW_WIDTH{1'b0}});
    assign win_end    = win_active &&
                        (win_cnt_q >= (adc_window_len - {{(WINDOW_WIDTH-1){1'b0}}, 1'b1}));
    assign acc_clr    = adc_stats_clr || !win_active || win_end;
    assign acc_latch  = (count_en && (acc_cnt != {CNT_WIDTH{1'b1}})) ?
                        acc_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : acc_cnt;

    // status, stickies and window bookkeeping
    always_comb begin
        locked_d      = (state_d == S_LOCKED);
        err_sticky_d  = err_sticky_q;
        loss_sticky_d = loss_sticky_q;
        win_cnt_d     = win_cnt_q;
        win_err_d     = win_err_q;
        win_done_d    = 1'b0;
        if (adc_stats_clr) begin
            err_sticky_d  = 1'b0;
            loss_sticky_d = 1'b0;
            win_cnt_d     = {WINDOW_WIDTH{1'b0}};
            win_err_d     = {CNT_WIDTH{1'b0}};
        end else begin
            err_sticky_d  = err_sticky_q | count_en;
            loss_sticky_d = loss_sticky_q | loss_ev;
            if (win_end) begin
                win_cnt_d  = {WINDOW_WIDTH{1'b0}};
                win_err_d  = acc_latch;
                win_done_d = 1'b1;
            end else if (win_active) begin
                win_cnt_d = win_cnt_q + {{(WINDOW_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                win_cnt_d = {WINDOW_WIDTH{1'b0}};
            end
        end
    end

    // state and status registers
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q       <= S_OOS;
            settle_q      <= {SETTLE_WIDTH{1'b0}};
            pnseq_q       <= 4'd0;
            locked_q      <= 1'b0;
            err_sticky_q  <= 1'b0;
            loss_sticky_q <= 1'b0;
            win_cnt_q     <= {WINDOW_WIDTH{1'b0}};
            win_err_q     <= {CNT_WIDTH{1'b0}};
            win_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            pnseq_q       <= adc_pnseq_sel;
            locked_q      <= locked_d;
            err_sticky_q  <= err_sticky_d;
            loss_sticky_q <= loss_sticky_d;
            win_cnt_q     <= win_cnt_d;
            win_err_q     <= win_err_d;
            win_done_q    <= win_done_d;
        end
    end

    ad_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(adc_clk), .rst(adc_rst), .clr(adc_stats_clr), .inc(count_en), .cnt_q(adc_err_cnt)
    );

    ad_sat_counter #(.WIDTH(CNT_WIDTH)) u_loss_cnt (
        .clk(adc_clk), .rst(adc_rst), .clr(adc_stats_clr), .inc(loss_ev), .cnt_q(adc_loss_cnt)
    );

    ad_sat_counter #(.WIDTH(CNT_WIDTH)) u_acc_cnt (
        .clk(adc_clk), .rst(adc_rst), .clr(acc_clr), .inc(count_en), .cnt_q(acc_cnt)
    );

    assign adc_locked      = locked_q;
    assign adc_err_sticky  = err_sticky_q;
    assign adc_loss_sticky = loss_sticky_q;
    assign adc_win_err_cnt = win_err_q;
    assign adc_win_done    = win_done_q;

`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
    logic [15:0] run_cnt;
    logic [15:0] run_next;
    logic [15:0] burst_q, burst_d;

    ad_sat_counter #(.WIDTH(16)) u_run_cnt (
        .clk(adc_clk), .rst(adc_rst), .clr(adc_stats_clr || !count_en), .inc(count_en),
        .cnt_q(run_cnt)
    );

    assign run_next = (run_cnt != 16'hFFFF) ? run_cnt + 16'd1 : run_cnt;

    // longest run of consecutive counted errors
    always_comb begin
        burst_d = burst_q;
        if (adc_stats_clr) begin
            burst_d = 16'd0;
        end else if (count_en && (run_next > burst_q)) begin
            burst_d = run_next;
        end else begin
            burst_d = burst_q;
        end
    end

    // burst maximum register
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            burst_q <= 16'd0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign adc_burst_max = burst_q;
`endif

endmodule

// File: tb/tb_axi_adc_jesd204_pn_stats.sv
// Self-checking bench for axi_adc_jesd204_pn_stats; window results checked via a scoreboard queue.
module tb_axi_adc_jesd204_pn_stats;

    logic        clk = 1'b0;
    logic        rst, oos, err, clr;
    logic [3:0]  sel;
    logic [23:0] wlen;

    logic        locked, err_sticky, loss_sticky, win_done;
    logic [31:0] err_cnt, loss_cnt, win_err;
    logic        locked4, err_sticky4, loss_sticky4, win_done4;
    logic [3:0]  err_cnt4, loss_cnt4, win_err4;
`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
    logic [15:0] burst_max, burst_max4;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    axi_adc_jesd204_pn_stats #(.CNT_WIDTH(32), .WINDOW_WIDTH(24), .SETTLE_CYCLES(16)) u_dut (
        .adc_clk(clk), .adc_rst(rst), .adc_pn_oos(oos), .adc_pn_err(err),
        .adc_pnseq_sel(sel), .adc_stats_clr(clr), .adc_window_len(wlen),
        .adc_locked(locked), .adc_err_cnt(err_cnt), .adc_loss_cnt(loss_cnt),
        .adc_err_sticky(err_sticky), .adc_loss_sticky(loss_sticky),
        .adc_win_err_cnt(win_err), .adc_win_done(win_done)
`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
        , .adc_burst_max(burst_max)
`endif
    );

    axi_adc_jesd204_pn_stats #(.CNT_WIDTH(4), .WINDOW_WIDTH(24), .SETTLE_CYCLES(16)) u_dut4 (
        .adc_clk(clk), .adc_rst(rst), .adc_pn_oos(oos), .adc_pn_err(err),
        .adc_pnseq_sel(sel), .adc_stats_clr(clr), .adc_window_len(wlen),
        .adc_locked(locked4), .adc_err_cnt(err_cnt4), .adc_loss_cnt(loss_cnt4),
        .adc_err_sticky(err_sticky4), .adc_loss_sticky(loss_sticky4),
        .adc_win_err_cnt(win_err4), .adc_win_done(win_done4)
`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
        , .adc_burst_max(burst_max4)
`endif
    );

    // advance one edge, sample after it and score any window result
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (win_done === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL win_done_unexpected: got pulse with value %0d, required no pulse", win_err);
            end else begin
                e = exp_q.pop_front();
                if (win_err !== e) begin
                    fails++;
                    $display("FAIL win_err_cnt: got %0d, required %0d", win_err, e);
                end
            end
        end
    endtask

    task automatic relock();
        int n;
        n = 0;
        oos = 1'b0;
        while (locked !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL relock: got locked=%0b, required 1 within 40 cycles", locked);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; oos = 1'b1; err = 1'b0; clr = 1'b0; sel = 4'd0; wlen = 24'd0;
        repeat (3) tick();
        tests++;
        if ({locked, err_sticky, loss_sticky, win_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 0000", {locked, err_sticky, loss_sticky, win_done});
        end
        tests++;
        if (err_cnt !== 32'd0 || loss_cnt !== 32'd0 || win_err !== 32'd0) begin
            fails++;
            $display("FAIL reset_counts: got err=%0d loss=%0d win=%0d, required 0 0 0", err_cnt, loss_cnt, win_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_settle();
        int n;
        n = 0;
        oos = 1'b0;
        err = 1'b1;
        while (locked !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        err = 1'b0;
        tests++;
        if (n != 17) begin
            fails++;
            $display("FAIL settle_latency: got %0d edges, required 17", n);
        end
        tests++;
        if (err_cnt !== 32'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL settle_no_count: got err=%0d sticky=%0b, required 0 0", err_cnt, err_sticky);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) begin
            err = 1'b1; tick();
            err = 1'b0; tick();
        end
        tests++;
        if (err_cnt !== 32'd5 || err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL err_count: got err=%0d sticky=%0b, required 5 1", err_cnt, err_sticky);
        end
    endtask

    task automatic test_loss();
        oos = 1'b1; err = 1'b1;
        tick();
        err = 1'b0;
        tests++;
        if (locked !== 1'b0 || loss_cnt !== 32'd1 || loss_sticky !== 1'b1) begin
            fails++;
            $display("FAIL loss: got locked=%0b loss=%0d sticky=%0b, required 0 1 1", locked, loss_cnt, loss_sticky);
        end
        tests++;
        if (err_cnt !== 32'd5) begin
            fails++;
            $display("FAIL err_with_oos: got %0d, required 5", err_cnt);
        end
    endtask

    task automatic test_window();
        relock();
        wlen = 24'd100;
        exp_q.push_back(32'd3);
        for (int i = 0; i < 100; i++) begin
            err = (i == 10 || i == 50 || i == 99);
            tick();
        end
        err = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL win_pulse_missing: got %0d pending, required 0", exp_q.size());
        end
        for (int i = 0; i < 20; i++) begin
            err = (i == 5);
            tick();
        end
        err = 1'b0; oos = 1'b1;
        tick();
        tests++;
        if (win_err !== 32'd3 || loss_cnt !== 32'd2 || err_cnt !== 32'd9) begin
            fails++;
            $display("FAIL win_abort: got win=%0d loss=%0d err=%0d, required 3 2 9", win_err, loss_cnt, err_cnt);
        end
        // shrink the length below the running count: window closes immediately
        relock();
        repeat (30) tick();
        wlen = 24'd10; err = 1'b1;
        exp_q.push_back(32'd1);
        tick();
        err = 1'b0; wlen = 24'd0;
        tick();
        tests++;
        if (exp_q.size() != 0 || err_cnt !== 32'd10) begin
            fails++;
            $display("FAIL win_shrink: got pending=%0d err=%0d, required 0 10", exp_q.size(), err_cnt);
        end
    endtask

    task automatic test_len1();
        wlen = 24'd1;
        for (int i = 0; i < 3; i++) begin
            err = (i != 1);
            exp_q.push_back((i != 1) ? 32'd1 : 32'd0);
            tick();
        end
        err = 1'b0; wlen = 24'd0;
        tick();
        tests++;
        if (exp_q.size() != 0 || err_cnt !== 32'd12) begin
            fails++;
            $display("FAIL len1: got pending=%0d err=%0d, required 0 12", exp_q.size(), err_cnt);
        end
    endtask

    task automatic test_clear();
        err = 1'b1; clr = 1'b1;
        tick();
        err = 1'b0; clr = 1'b0;
        tests++;
        if (err_cnt !== 32'd0 || loss_cnt !== 32'd0 || win_err !== 32'd0) begin
            fails++;
            $display("FAIL clear_counts: got err=%0d loss=%0d win=%0d, required 0 0 0", err_cnt, loss_cnt, win_err);
        end
        tests++;
        if ({err_sticky, loss_sticky, locked} !== 3'b001) begin
            fails++;
            $display("FAIL clear_flags: got %b, required 001", {err_sticky, loss_sticky, locked});
        end
    endtask

    task automatic test_pnseq();
        sel = 4'd1;
        tick();
        tests++;
        if (locked !== 1'b0 || loss_cnt !== 32'd0 || loss_sticky !== 1'b0) begin
            fails++;
            $display("FAIL pnseq: got locked=%0b loss=%0d sticky=%0b, required 0 0 0", locked, loss_cnt, loss_sticky);
        end
        relock();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            err = 1'b1; tick();
            err = 1'b0; tick();
        end
        tests++;
        if (err_cnt !== 32'd20) begin
            fails++;
            $display("FAIL sat_wide: got %0d, required 20", err_cnt);
        end
        tests++;
        if (err_cnt4 !== 4'd15) begin
            fails++;
            $display("FAIL sat_narrow: got %0d, required 15", err_cnt4);
        end
    endtask

`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
    task automatic test_burst();
        clr = 1'b1; tick(); clr = 1'b0;
        err = 1'b1; repeat (3) tick();
        err = 1'b0; tick();
        err = 1'b1; repeat (7) tick();
        err = 1'b0; tick();
        tests++;
        if (burst_max !== 16'd7 || err_cnt !== 32'd10) begin
            fails++;
            $display("FAIL burst: got max=%0d err=%0d, required 7 10", burst_max, err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_settle();
        test_errors();
        test_loss();
        test_window();
        test_len1();
        test_clear();
        test_pnseq();
        test_saturation();
`ifdef AXI_ADC_JESD204_PN_STATS_BURST_EN
        test_burst();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
